// File: rtl/multi_sqwave_pkg.sv
// Shared types and helpers for the multi-channel square-wave generator.
package multi_sqwave_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_HIGH = 2'b01,
    ST_LOW  = 2'b10
  } state_e;

  function automatic int cnt_width(input int cw, input int tick_div);
    return cw + $clog2(tick_div + 1);
  endfunction

  // A period starts with HIGH if it has a high phase, else LOW, else nothing to run.
  function automatic state_e start_state(input logic on_nz, input logic off_nz);
    state_e s;
    if (on_nz) begin
      s = ST_HIGH;
    end else if (off_nz) begin
      s = ST_LOW;
    end else begin
      s = ST_IDLE;
    end
    return s;
  endfunction

endpackage

// File: rtl/sqwave_chan.sv
// One square-wave channel: shadow/active lengths, phase counter, registered out and period_done.
module sqwave_chan
  import multi_sqwave_pkg::*;
#(
  parameter int CW       = 4,
  parameter int TICK_DIV = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          ld,
  input  logic [CW-1:0] on_len,
  input  logic [CW-1:0] off_len,
  output logic          out,
  output logic          period_done
);

  localparam int CNTW = cnt_width(CW, TICK_DIV);
  localparam logic [CNTW-1:0] DIV = CNTW'(TICK_DIV);

  // Only evaluated for non-zero lengths, so the zero-length wrap is never used.
  function automatic logic [CNTW-1:0] term_cnt(input logic [CW-1:0] len);
    return CNTW'(len) * DIV - CNTW'(1);
  endfunction

  state_e          r_state;
  logic [CNTW-1:0] r_cnt;
  logic [CW-1:0]   r_sh_on, r_sh_off;
  logic [CW-1:0]   r_act_on, r_act_off;
  logic            r_out, r_done;

  state_e          w_nxt_state, w_bnd_state;
  logic [CNTW-1:0] w_nxt_cnt;
  logic [CW-1:0]   w_nxt_on, w_nxt_off;
  logic [CW-1:0]   w_bnd_on, w_bnd_off;
  logic [CNTW-1:0] w_tc_on, w_tc_off, w_tc_on_n, w_tc_off_n;
  logic            w_done_n;

  // Boundary load bypasses the shadow when a load lands on the same edge.
  assign w_bnd_on    = ld ? on_len  : r_sh_on;
  assign w_bnd_off   = ld ? off_len : r_sh_off;
  assign w_bnd_state = start_state(w_bnd_on != '0, w_bnd_off != '0);
  assign w_tc_on     = term_cnt(r_act_on);
  assign w_tc_off    = term_cnt(r_act_off);
  assign w_tc_on_n   = term_cnt(w_nxt_on);
  assign w_tc_off_n  = term_cnt(w_nxt_off);

  // Next-state, counter and active-length selection.
  always_comb begin
    w_nxt_state = r_state;
    w_nxt_cnt   = r_cnt;
    w_nxt_on    = r_act_on;
    w_nxt_off   = r_act_off;
    if (!en) begin
      w_nxt_state = ST_IDLE;
      w_nxt_cnt   = '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_nxt_state = w_bnd_state;
          w_nxt_on    = w_bnd_on;
          w_nxt_off   = w_bnd_off;
          w_nxt_cnt   = '0;
        end
        ST_HIGH: begin
          if (r_cnt != w_tc_on) begin
            w_nxt_cnt = r_cnt + CNTW'(1);
          end else if (r_act_off != '0) begin
            w_nxt_state = ST_LOW;
            w_nxt_cnt   = '0;
          end else begin
            w_nxt_state = w_bnd_state;
            w_nxt_on    = w_bnd_on;
            w_nxt_off   = w_bnd_off;
            w_nxt_cnt   = '0;
          end
        end
        ST_LOW: begin
          if (r_cnt != w_tc_off) begin
            w_nxt_cnt = r_cnt + CNTW'(1);
          end else begin
            w_nxt_state = w_bnd_state;
            w_nxt_on    = w_bnd_on;
            w_nxt_off   = w_bnd_off;
            w_nxt_cnt   = '0;
          end
        end
        default: begin
          w_nxt_state = ST_IDLE;
          w_nxt_cnt   = '0;
        end
      endcase
    end
  end

  // period_done is registered one cycle early so it is high during the period's last clock.
  always_comb begin
    if ((w_nxt_state == ST_LOW) && (w_nxt_cnt == w_tc_off_n)) begin
      w_done_n = 1'b1;
    end else if ((w_nxt_state == ST_HIGH) && (w_nxt_off == '0) && (w_nxt_cnt == w_tc_on_n)) begin
      w_done_n = 1'b1;
    end else begin
      w_done_n = 1'b0;
    end
  end

  // State, lengths and outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_sh_on   <= '0;
      r_sh_off  <= '0;
      r_act_on  <= '0;
      r_act_off <= '0;
      r_out     <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      if (ld) begin
        r_sh_on  <= on_len;
        r_sh_off <= off_len;
      end
      r_state   <= w_nxt_state;
      r_cnt     <= w_nxt_cnt;
      r_act_on  <= w_nxt_on;
      r_act_off <= w_nxt_off;
      r_out     <= (w_nxt_state == ST_HIGH);
      r_done    <= w_done_n;
    end
  end

  assign out         = r_out;
  assign period_done = r_done;

endmodule

// File: rtl/multi_sqwave_gen.sv
// Multi-channel programmable square-wave/PWM generator; channels are fully independent.
module multi_sqwave_gen #(
  parameter int CH       = 2,
  parameter int CW       = 4,
  parameter int TICK_DIV = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CH-1:0]    en,
  input  logic [CH-1:0]    ld,
  input  logic [CH*CW-1:0] on_len,
  input  logic [CH*CW-1:0] off_len,
  output logic [CH-1:0]    out,
  output logic [CH-1:0]    period_done
);

  for (genvar gi = 0; gi < CH; gi++) begin : g_chan
    sqwave_chan #(
      .CW       (CW),
      .TICK_DIV (TICK_DIV)
    ) u_chan (
      .clk         (clk),
      .rst         (rst),
      .en          (en[gi]),
      .ld          (ld[gi]),
      .on_len      (on_len[gi*CW +: CW]),
      .off_len     (off_len[gi*CW +: CW]),
      .out         (out[gi]),
      .period_done (period_done[gi])
    );
  end

endmodule

// File: tb/tb_multi_sqwave_gen.sv
// Directed self-checking bench for multi_sqwave_gen (CH=2, CW=4, TICK_DIV=5).
module tb_multi_sqwave_gen;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] en, ld;
  logic [7:0] on_len, off_len;
  logic [1:0] out, period_done;

  int n_checks = 0;
  int n_fail   = 0;

  multi_sqwave_gen #(.CH(2), .CW(4), .TICK_DIV(5)) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .ld          (ld),
    .on_len      (on_len),
    .off_len     (off_len),
    .out         (out),
    .period_done (period_done)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Check n cycles of a constant level on one channel; done expected only on the last one if asked.
  task automatic seg(input string tag, input int ch, input logic val, input int n, input logic last_done);
    for (int i = 0; i < n; i++) begin
      check_eq({tag, "_out"}, 32'(out[ch]), 32'(val));
      check_eq({tag, "_done"}, 32'(period_done[ch]), 32'((i == n - 1) && last_done));
      tick();
    end
  endtask

  task automatic load0(input logic [3:0] on_v, input logic [3:0] off_v);
    on_len[3:0]  = on_v;
    off_len[3:0] = off_v;
    ld[0]        = 1'b1;
  endtask

  initial begin
    // 1: reset with arbitrary inputs, then idle with en low
    rst = 1'b1; en = 2'b11; ld = 2'b11; on_len = 8'hff; off_len = 8'hff;
    tick(); tick();
    check_eq("rst_out", 32'(out), 32'h0);
    check_eq("rst_done", 32'(period_done), 32'h0);
    rst = 1'b0; en = 2'b00; ld = 2'b00;
    tick(); tick(); tick();
    check_eq("idle_out", 32'(out), 32'h0);
    check_eq("idle_done", 32'(period_done), 32'h0);

    // 2: ch0 3/2
    load0(4'd3, 4'd2);
    tick();
    ld = 2'b00; en = 2'b01;
    tick();
    seg("t2_h1", 0, 1'b1, 15, 1'b0);
    seg("t2_l1", 0, 1'b0, 10, 1'b1);
    check_eq("t2_out1", 32'(out[1]), 32'h0);
    seg("t2_h2", 0, 1'b1, 15, 1'b0);
    seg("t2_l2", 0, 1'b0, 10, 1'b1);
    check_eq("t2_done1", 32'(period_done[1]), 32'h0);

    // 3: ld 1/1 at clock 7 of HIGH -> current period unchanged
    seg("t3_h0", 0, 1'b1, 7, 1'b0);
    load0(4'd1, 4'd1);
    seg("t3_h7", 0, 1'b1, 1, 1'b0);
    ld = 2'b00;
    seg("t3_hr", 0, 1'b1, 7, 1'b0);
    seg("t3_l", 0, 1'b0, 10, 1'b1);
    seg("t3_h55", 0, 1'b1, 5, 1'b0);
    seg("t3_l55", 0, 1'b0, 5, 1'b1);
    // back to 3/2, then ld 1/1 on the terminal-count cycle
    load0(4'd3, 4'd2);
    seg("t3_h55b", 0, 1'b1, 1, 1'b0);
    ld = 2'b00;
    seg("t3_h55c", 0, 1'b1, 4, 1'b0);
    seg("t3_l55b", 0, 1'b0, 5, 1'b1);
    seg("t3_h32", 0, 1'b1, 15, 1'b0);
    seg("t3_l32", 0, 1'b0, 9, 1'b0);
    load0(4'd1, 4'd1);
    seg("t3_tc", 0, 1'b0, 1, 1'b1);
    ld = 2'b00;
    seg("t3_hby", 0, 1'b1, 5, 1'b0);
    seg("t3_lby", 0, 1'b0, 5, 1'b1);

    // 4: degenerate 0/4
    load0(4'd0, 4'd4);
    seg("t4_a", 0, 1'b1, 1, 1'b0);
    ld = 2'b00;
    seg("t4_b", 0, 1'b1, 4, 1'b0);
    seg("t4_c", 0, 1'b0, 5, 1'b1);
    seg("t4_z1", 0, 1'b0, 20, 1'b1);
    seg("t4_z2", 0, 1'b0, 20, 1'b1);
    // 4/0
    load0(4'd4, 4'd0);
    seg("t4_d", 0, 1'b0, 1, 1'b0);
    ld = 2'b00;
    seg("t4_e", 0, 1'b0, 19, 1'b1);
    seg("t4_o1", 0, 1'b1, 20, 1'b1);
    seg("t4_o2", 0, 1'b1, 20, 1'b1);
    // 0/0 -> idle, then 2/2 by bypass
    load0(4'd0, 4'd0);
    seg("t4_f", 0, 1'b1, 1, 1'b0);
    ld = 2'b00;
    seg("t4_g", 0, 1'b1, 19, 1'b1);
    seg("t4_idle", 0, 1'b0, 5, 1'b0);
    load0(4'd2, 4'd2);
    seg("t4_h", 0, 1'b0, 1, 1'b0);
    ld = 2'b00;
    seg("t4_h22", 0, 1'b1, 10, 1'b0);
    seg("t4_l22", 0, 1'b0, 10, 1'b1);
    seg("t4_h22b", 0, 1'b1, 10, 1'b0);

    // 5: en drop at clock 6 of HIGH, re-enable, reset mid-LOW
    load0(4'd3, 4'd2);
    seg("t5_a", 0, 1'b0, 1, 1'b0);
    ld = 2'b00;
    seg("t5_b", 0, 1'b0, 9, 1'b1);
    seg("t5_h", 0, 1'b1, 6, 1'b0);
    en[0] = 1'b0;
    seg("t5_drop", 0, 1'b1, 1, 1'b0);
    seg("t5_off", 0, 1'b0, 5, 1'b0);
    en[0] = 1'b1;
    seg("t5_re", 0, 1'b0, 1, 1'b0);
    seg("t5_hfull", 0, 1'b1, 15, 1'b0);
    seg("t5_l", 0, 1'b0, 3, 1'b0);
    rst = 1'b1;
    seg("t5_rst", 0, 1'b0, 1, 1'b0);
    rst = 1'b0;
    seg("t5_post", 0, 1'b0, 5, 1'b0);
    check_eq("t5_out_vec", 32'(out), 32'h0);
    check_eq("t5_done_vec", 32'(period_done), 32'h0);

    // 6: ch0 1/1 and ch1 15/15 concurrently
    on_len = 8'hf1; off_len = 8'hf1; ld = 2'b11; en = 2'b11;
    tick();
    ld = 2'b00;
    for (int c = 0; c < 300; c++) begin
      check_eq("t6_out0", 32'(out[0]), 32'((c % 10) < 5));
      check_eq("t6_done0", 32'(period_done[0]), 32'((c % 10) == 9));
      check_eq("t6_out1", 32'(out[1]), 32'((c % 150) < 75));
      check_eq("t6_done1", 32'(period_done[1]), 32'((c % 150) == 149));
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
